packet_forwarder: RTL

- Read-out side of the packet RAM: once the filter accepts a packet, streams the stored words out over a valid/ready stream.
- Drives the packet RAM's shared address, read enable and 2-word read data. Uses only the upper word, which is the word at the issued address.
- Handles the RAM's 1-cycle read latency and downstream backpressure with a 2-entry output buffer.
- Sits between packetmem's RAM port and the egress interface.

---
 rtl/packet_forwarder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/packet_forwarder.sv
// Packet RAM read-out: streams a stored packet over valid/ready with a 2-entry skid buffer.
// Optional PKT_FWD_TKEEP_EN: byte-granular length input and a per-beat tkeep output.
module packet_forwarder #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     start_addr,
`ifdef PKT_FWD_TKEEP_EN
    input  logic [ADDR_WIDTH+2:0]     len_bytes,
`else
    input  logic [ADDR_WIDTH:0]       len_words,
`endif
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic                      ram_rd_en,
    input  logic [2*DATA_WIDTH-1:0]   ram_do,
    output logic [DATA_WIDTH-1:0]     tdata,
    output logic                      tvalid,
    input  logic                      tready,
`ifdef PKT_FWD_TKEEP_EN
    output logic [DATA_WIDTH/8-1:0]   tkeep,
`endif
    output logic                      tlast
);
    localparam int BPW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

    state_t                     state;
    logic [ADDR_WIDTH-1:0]      rd_ptr;
    logic [ADDR_WIDTH:0]        issue_left;
    logic                       inflight;
    logic                       inflight_last;
    logic [1:0][DATA_WIDTH-1:0] buf_data;
    logic [1:0]                 buf_last;
    logic                       head;
    logic                       tail;
    logic [1:0]                 occ;
    logic [2:0]                 committed;
    logic                       pop;
    logic                       issue;
    logic [ADDR_WIDTH:0]        req_words;
    logic                       unused_lo;

    // The lower RAM word belongs to the neighbouring address and is never needed here.
    assign unused_lo = ^ram_do[DATA_WIDTH-1:0];

`ifdef PKT_FWD_TKEEP_EN
    localparam int BSH = $clog2(BPW);

    logic [ADDR_WIDTH+3:0] bytes_rnd;
    logic [BPW-1:0]        len_keep;
    logic [BPW-1:0]        last_keep;
    logic [1:0][BPW-1:0]   buf_keep;
    logic                  unused_rnd;

    assign bytes_rnd  = {1'b0, len_bytes} + (ADDR_WIDTH+4)'(BPW-1);
    assign req_words  = bytes_rnd[ADDR_WIDTH+BSH:BSH];
    assign unused_rnd = ^{bytes_rnd[ADDR_WIDTH+3:ADDR_WIDTH+BSH+1], bytes_rnd[BSH-1:0]};
    // Big-endian bytes: a partial final word keeps its leading (MSB) bytes.
    assign len_keep   = (len_bytes[BSH-1:0] == '0) ? {BPW{1'b1}}
                                                   : ~({BPW{1'b1}} >> len_bytes[BSH-1:0]);
    assign tkeep      = buf_keep[head];
`else
    assign req_words  = len_words;
`endif

    // Issue only when the word would still fit after everything already owed to the buffer.
    assign pop       = tvalid & tready;
    assign committed = 3'(occ) + 3'(inflight) - 3'(pop);
    assign issue     = (state == STREAM) && (issue_left != '0) && (committed < 3'd2);
    assign ram_rd_en = issue;
    assign ram_addr  = rd_ptr;
    assign tvalid    = (occ != 2'd0);
    assign tdata     = buf_data[head];
    assign tlast     = tvalid & buf_last[head];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            rd_ptr        <= '0;
            issue_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            buf_data      <= '0;
            buf_last      <= '0;
            head          <= 1'b0;
            tail          <= 1'b0;
            occ           <= 2'd0;
`ifdef PKT_FWD_TKEEP_EN
            last_keep     <= '0;
            buf_keep      <= '0;
`endif
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (issue_left == (ADDR_WIDTH+1)'(1));
            if (issue) begin
                rd_ptr     <= rd_ptr + ADDR_WIDTH'(1);
                issue_left <= issue_left - (ADDR_WIDTH+1)'(1);
            end
            if (inflight) begin
                buf_data[tail] <= ram_do[2*DATA_WIDTH-1:DATA_WIDTH];
                buf_last[tail] <= inflight_last;
`ifdef PKT_FWD_TKEEP_EN
                buf_keep[tail] <= inflight_last ? last_keep : {BPW{1'b1}};
`endif
                tail <= ~tail;
            end
            if (pop)
                head <= ~head;
            occ <= occ + 2'(inflight) - 2'(pop);

            case (state)
                IDLE: begin
                    if (start) begin
                        if (req_words != '0) begin
                            rd_ptr     <= start_addr;
                            issue_left <= req_words;
                            busy       <= 1'b1;
                            state      <= STREAM;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
`ifdef PKT_FWD_TKEEP_EN
                        last_keep <= len_keep;
`endif
                    end
                end
                STREAM: begin
                    if (pop && tlast) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
